id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core; sits directly upstream of the ALU and drives its A, B and ALUControl inputs.
- Registers decoded operands and control, and decodes ALUOp/funct into the 4-bit ALU code.
- Applies EX/MEM and MEM/WB operand forwarding combinationally in EX.
- Detects load-use hazards and inserts a one-cycle bubble.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-file address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  downstream hold; register keeps contents
flush  in  1  branch-taken squash; load a bubble
id_valid  in  1  ID stage holds a real instruction
id_rs_data  in  DATA_W  Read Data 1 from register file
id_rt_data  in  DATA_W  Read Data 2 from register file
id_imm  in  DATA_W  sign-extended immediate
id_rs  in  REG_AW  rs field
id_rt  in  REG_AW  rt field
id_rd  in  REG_AW  rd field
id_ALUOp  in  2  main-decoder ALU class
id_funct  in  6  instruction funct field
id_ctrl  in  6  {RegDst, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg}
exmem_RegWrite  in  1  EX/MEM writes a register
exmem_rd  in  REG_AW  EX/MEM destination
exmem_result  in  DATA_W  EX/MEM ALU result
memwb_RegWrite  in  1  MEM/WB writes a register
memwb_rd  in  REG_AW  MEM/WB destination
memwb_result  in  DATA_W  MEM/WB write-back value
A  out  DATA_W  ALU operand 1 (forwarded rs)
B  out  DATA_W  ALU operand 2 (imm or forwarded rt)
ALUControl  out  4  ALU operation code
ex_WriteData  out  DATA_W  forwarded rt, store data
ex_WriteReg  out  REG_AW  RegDst ? rd : rt
ex_ctrl  out  4  {RegWrite, MemRead, MemWrite, MemtoReg} to EX/MEM
ex_valid  out  1  EX holds a real instruction
load_use_stall  out  1  hold PC and IF/ID this cycle
illegal_op  out  1  registered funct not decodable

Behaviour:
- Reset, asynchronous on rst_n=0: all registers 0. Outputs: ex_valid=0, ex_ctrl=0, ALUControl=0000, A=B=0, ex_WriteReg=0, load_use_stall=0, illegal_op=0.
- Register update priority on each rising edge:
  - flush: bubble (valid, ctrl, ALUControl and reg fields = 0; data don't-care, cleared to 0).
  - else stall: hold all contents.
  - else load_use_stall: bubble.
  - else load all id_* inputs.
- Latency: one cycle from ID inputs to registered state. A, B and the other EX outputs are combinational from that state plus the forwarding inputs.
- ALU decode is combinational on id_* and registered with the rest:
  - ALUOp 00 -> 0010 (ADD: lw, sw, addi)
  - ALUOp 01 -> 0110 (SUB: beq)
  - ALUOp 11 -> 0001 (OR: ori)
  - ALUOp 10, by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 100110 -> 0011, 101010 -> 0111.
  - Any other funct -> 1111 with illegal_op=1. The ALU returns 0 for 1111.
- Forwarding, applied per source (rs_q gives fwdA; rt_q gives fwdB):
  - EX/MEM match: exmem_RegWrite && exmem_rd != 0 && exmem_rd == src -> exmem_result.
  - Else MEM/WB match, same rule -> memwb_result.
  - Else the registered read data.
  - EX/MEM has priority when both match. Register $0 is never forwarded.
- Operand outputs: A = fwdA; B = ALUSrc_q ? imm_q : fwdB; ex_WriteData = fwdB, regardless of ALUSrc.
- load_use_stall = ex_valid && MemRead_q && rt_q != 0 && (rt_q == id_rs || rt_q == id_rt) && id_valid.
- Reset mid-operation aborts immediately; there is no partial state.
- Bubbles carry RegWrite=0, so they never trigger forwarding downstream.

Decomposition:
- Shared package mips_pkg: ALU code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLT, ALU_BAD=1111), ALUOp encodings, funct constants, ctrl bit indices.
- One natural sub-module: alu_control, a combinational ALUOp/funct decoder that is instantiated before the register.
- Forwarding and hazard logic stay inline.

Test Plan:
- Reset: rst_n low with busy inputs -> all outputs 0, ALUControl=0000; release -> first edge loads id_*.
- R-type decode: ALUOp=10, funct=101010, rs_data=-5, rt_data=3 -> ALUControl=0111, A=FFFFFFFB, B=3; funct=000000 -> 1111 and illegal_op=1.
- Forwarding priority: rs_q=8, exmem_rd=8 with result 0x11, memwb_rd=8 with result 0x22, both RegWrite=1 -> A=0x11; drop exmem_RegWrite -> A=0x22; set rs_q=0 -> A = registered data.
- Load-use: lw to rt=9 in EX, ID uses rs=9 -> load_use_stall=1, next edge ex_valid=0 and ex_ctrl=0, then the consumer loads.
- stall and flush together -> bubble (flush wins); stall alone for 3 cycles -> A, B, ALUControl unchanged.
- ALUSrc=1 with imm=0xFFFFFFF0 and rt forwarded 0x55 -> B=FFFFFFF0, ex_WriteData=0x55.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS constants: ALU operation codes, main-decoder ALUOp classes, R-type funct values, ID/EX control bit positions.
// No logic, so no latency.
// No flow control.
package mips_pkg;

    // ALU operation codes seen by the EX-stage ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_BAD = 4'b1111;   // ALU returns 0 for this code

    // Main-decoder ALUOp classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00; // lw, sw, addi
    localparam logic [1:0] ALUOP_SUB   = 2'b01; // beq
    localparam logic [1:0] ALUOP_RTYPE = 2'b10; // decode funct
    localparam logic [1:0] ALUOP_OR    = 2'b11; // ori

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // Bit positions in the 6-bit id_ctrl word
    localparam int CTRL_REGDST   = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_MEMTOREG = 0;

endpackage

// File: rtl/id_ex_stage_alu_control.sv
// ALU control decoder: maps ALUOp class and funct to the 4-bit ALU code.
// Purely combinational, zero latency.
// No flow control.
module alu_control
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctl,
    output logic       illegal
);

    // Non-R-type classes ignore funct; R-type funct outside the known set is flagged
    always_comb begin
        alu_ctl = ALU_BAD;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_ctl = ALU_ADD;
            ALUOP_SUB: alu_ctl = ALU_SUB;
            ALUOP_OR:  alu_ctl = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: alu_ctl = ALU_ADD;
                    FUNCT_SUB: alu_ctl = ALU_SUB;
                    FUNCT_AND: alu_ctl = ALU_AND;
                    FUNCT_OR:  alu_ctl = ALU_OR;
                    FUNCT_XOR: alu_ctl = ALU_XOR;
                    FUNCT_SLT: alu_ctl = ALU_SLT;
                    default: begin
                        alu_ctl = ALU_BAD;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU decode, EX/MEM + MEM/WB operand forwarding and load-use bubble insertion.
// One cycle from id_* to registered state; A/B/EX outputs are combinational from that state and forwarding inputs.
// stall holds contents, flush or a load-use hazard loads a bubble (flush wins over stall).
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [1:0]        id_ALUOp,
    input  logic [5:0]        id_funct,
    input  logic [5:0]        id_ctrl,
    input  logic              exmem_RegWrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_RegWrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [3:0]        ALUControl,
    output logic [DATA_W-1:0] ex_WriteData,
    output logic [REG_AW-1:0] ex_WriteReg,
    output logic [3:0]        ex_ctrl,
    output logic              ex_valid,
    output logic              load_use_stall,
    output logic              illegal_op
);

    logic [3:0]        id_alu_ctl;
    logic              id_illegal;

    logic              valid_q;
    logic [5:0]        ctrl_q;
    logic [3:0]        alu_ctl_q;
    logic              illegal_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic              bubble;

    // Decode happens in ID so only the 4-bit code is carried across the register
    alu_control u_alu_control (
        .alu_op  (id_ALUOp),
        .funct   (id_funct),
        .alu_ctl (id_alu_ctl),
        .illegal (id_illegal)
    );

    // A load in EX whose target feeds the instruction in ID must be held back one cycle
    assign load_use_stall = valid_q && ctrl_q[CTRL_MEMREAD] && (rt_q != '0)
                            && ((rt_q == id_rs) || (rt_q == id_rt)) && id_valid;

    // flush beats stall; a load-use bubble only applies when not stalled
    assign bubble = flush || (!stall && load_use_stall);

    // Pipeline register: bubbles clear everything so RegWrite=0 never forwards downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            alu_ctl_q <= '0;
            illegal_q <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else if (bubble) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            alu_ctl_q <= '0;
            illegal_q <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else if (!stall) begin
            valid_q   <= id_valid;
            ctrl_q    <= id_ctrl;
            alu_ctl_q <= id_alu_ctl;
            illegal_q <= id_illegal;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            rd_q      <= id_rd;
            rs_data_q <= id_rs_data;
            rt_data_q <= id_rt_data;
            imm_q     <= id_imm;
        end
    end

    // Forwarding: youngest producer (EX/MEM) wins; $0 is never forwarded
    always_comb begin
        fwd_a = rs_data_q;
        fwd_b = rt_data_q;
        if (exmem_RegWrite && (exmem_rd != '0) && (exmem_rd == rs_q))
            fwd_a = exmem_result;
        else if (memwb_RegWrite && (memwb_rd != '0) && (memwb_rd == rs_q))
            fwd_a = memwb_result;
        if (exmem_RegWrite && (exmem_rd != '0) && (exmem_rd == rt_q))
            fwd_b = exmem_result;
        else if (memwb_RegWrite && (memwb_rd != '0) && (memwb_rd == rt_q))
            fwd_b = memwb_result;
    end

    assign A            = fwd_a;
    assign B            = ctrl_q[CTRL_ALUSRC] ? imm_q : fwd_b;
    assign ex_WriteData = fwd_b;
    assign ex_WriteReg  = ctrl_q[CTRL_REGDST] ? rd_q : rt_q;
    assign ex_ctrl      = ctrl_q[3:0];
    assign ex_valid     = valid_q;
    assign ALUControl   = alu_ctl_q;
    assign illegal_op   = illegal_q;

endmodule
